// File: rtl/pipe_datapath_if.sv
// rtl/pipe_datapath_if.sv - instruction-in / result-out bundle for the two-stage datapath
interface pipe_datapath_if #(
    parameter int ADD_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 12
);
    logic                  in_valid;
    logic [ADD_WIDTH-1:0]  rs1;
    logic [ADD_WIDTH-1:0]  rs2;
    logic [ADD_WIDTH-1:0]  rd;
    logic                  RegWrite;
    logic [IMM_WIDTH-1:0]  ImmOp;
    logic                  ALUsrc;
    logic [2:0]            ALUctrl;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] ALUout;
    logic                  EQ;
    logic [DATA_WIDTH-1:0] a0;

    modport master (
        output in_valid, rs1, rs2, rd, RegWrite, ImmOp, ALUsrc, ALUctrl,
        input  out_valid, ALUout, EQ, a0
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, RegWrite, ImmOp, ALUsrc, ALUctrl,
        output out_valid, ALUout, EQ, a0
    );
endinterface

// File: rtl/pipe_datapath.sv
// rtl/pipe_datapath.sv - two-stage regfile/ALU datapath with EX->RD forwarding
module pipe_datapath #(
    parameter int ADD_WIDTH  = 5,
    parameter int DATA_WIDTH = 32,
    parameter int IMM_WIDTH  = 12,
    parameter int A0_INDEX   = 10
) (
    input  logic           clk,
    input  logic           rst,
    pipe_datapath_if.slave bus
);
    localparam int NUM_REGS = 2 ** ADD_WIDTH;
    localparam int SHW      = $clog2(DATA_WIDTH);
    localparam logic [ADD_WIDTH-1:0] A0_ADDR = ADD_WIDTH'(A0_INDEX);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic                  ex_valid_q;
    logic                  ex_regwrite_q;
    logic [ADD_WIDTH-1:0]  ex_rd_q;
    logic [2:0]            ex_ctrl_q;
    logic [DATA_WIDTH-1:0] ex_op1_q;
    logic [DATA_WIDTH-1:0] ex_op2_q;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] alu_out_q;
    logic                  eq_q;

    logic [DATA_WIDTH-1:0] op1_d;
    logic [DATA_WIDTH-1:0] op2_d;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  fwd_ok;
    logic                  ex_wr;

    assign imm_ext = DATA_WIDTH'($signed(bus.ImmOp));
    assign ex_wr   = ex_valid_q & ex_regwrite_q & (ex_rd_q != '0);
    assign fwd_ok  = ex_wr;

    // RD stage: the EX result bypasses the register file write that lands on the same edge
    always_comb begin
        op1_d = (bus.rs1 == '0) ? '0 : regs_q[bus.rs1];
        if (fwd_ok && (ex_rd_q == bus.rs1)) begin
            op1_d = alu_res;
        end
        if (bus.ALUsrc) begin
            op2_d = imm_ext;
        end else if (fwd_ok && (ex_rd_q == bus.rs2)) begin
            op2_d = alu_res;
        end else begin
            op2_d = (bus.rs2 == '0) ? '0 : regs_q[bus.rs2];
        end
    end

    always_comb begin
        alu_res = '0;
        case (ex_ctrl_q)
            3'b000: alu_res = ex_op1_q + ex_op2_q;
            3'b001: alu_res = ex_op1_q - ex_op2_q;
            3'b010: alu_res = ex_op1_q & ex_op2_q;
            3'b011: alu_res = ex_op1_q | ex_op2_q;
            3'b100: alu_res = ex_op1_q ^ ex_op2_q;
            3'b101: alu_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(ex_op1_q) < $signed(ex_op2_q))};
            3'b110: alu_res = ex_op1_q << ex_op2_q[SHW-1:0];
            3'b111: alu_res = ex_op1_q >> ex_op2_q[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q    <= 1'b0;
            ex_regwrite_q <= 1'b0;
            ex_rd_q       <= '0;
            ex_ctrl_q     <= '0;
            ex_op1_q      <= '0;
            ex_op2_q      <= '0;
        end else begin
            ex_valid_q    <= bus.in_valid;
            ex_regwrite_q <= bus.RegWrite;
            ex_rd_q       <= bus.rd;
            ex_ctrl_q     <= bus.ALUctrl;
            ex_op1_q      <= op1_d;
            ex_op2_q      <= op2_d;
        end
    end

    // EX/WB stage: reset takes priority, so an in-flight instruction never retires
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            eq_q        <= 1'b0;
        end else begin
            if (ex_wr) begin
                regs_q[ex_rd_q] <= alu_res;
            end
            out_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                alu_out_q <= alu_res;
                eq_q      <= (ex_op1_q == ex_op2_q);
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.ALUout    = alu_out_q;
    assign bus.EQ        = eq_q;
    assign bus.a0        = regs_q[A0_ADDR];
endmodule

// File: tb/tb_pipe_datapath.sv
// tb/tb_pipe_datapath.sv - directed vector bench for pipe_datapath
module tb_pipe_datapath;
    logic clk;
    logic rst;
    int   n_total;
    int   n_pass;

    pipe_datapath_if #(.ADD_WIDTH(5), .DATA_WIDTH(32), .IMM_WIDTH(12)) bus ();

    pipe_datapath #(
        .ADD_WIDTH(5), .DATA_WIDTH(32), .IMM_WIDTH(12), .A0_INDEX(10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs in row k belong to the instruction driven in row k-1
    typedef struct {
        logic        v;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic [11:0] imm;
        logic        src;
        logic [2:0]  ctrl;
        logic        ev;
        logic [31:0] eout;
        logic        eeq;
        logic [31:0] ea0;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                                logic we, logic [11:0] imm, logic src, logic [2:0] ctrl,
                                logic ev, logic [31:0] eout, logic eeq, logic [31:0] ea0);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.we = we; t.imm = imm;
        t.src = src; t.ctrl = ctrl; t.ev = ev; t.eout = eout; t.eeq = eeq; t.ea0 = ea0;
        return t;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(logic v, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                         logic we, logic [11:0] imm, logic src, logic [2:0] ctrl);
        bus.in_valid = v;
        bus.rs1      = rs1;
        bus.rs2      = rs2;
        bus.rd       = rd;
        bus.RegWrite = we;
        bus.ImmOp    = imm;
        bus.ALUsrc   = src;
        bus.ALUctrl  = ctrl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 12'd0, 1'b0, 3'd0);

        //          v  rs1 rs2 rd  we imm      src ctrl  ev  eout          eq  a0
        vecs.push_back(mk(1, 0, 0, 1, 1, 12'd5,   1, 3'd0, 0, 32'd0,        0, 32'd0));
        vecs.push_back(mk(1, 0, 0, 2, 1, 12'hFFF, 1, 3'd0, 1, 32'd5,        0, 32'd0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 12'd7,   1, 3'd0, 1, 32'hFFFFFFFF, 0, 32'd0));
        vecs.push_back(mk(1, 1, 1, 3, 1, 12'd0,   0, 3'd0, 1, 32'd7,        0, 32'd0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 12'd9,   1, 3'd0, 1, 32'd14,       1, 32'd0));
        vecs.push_back(mk(1, 0, 0, 4, 1, 12'd0,   0, 3'd0, 1, 32'd9,        0, 32'd0));
        vecs.push_back(mk(1, 0, 0, 1, 1, 12'd6,   1, 3'd0, 1, 32'd0,        1, 32'd0));
        vecs.push_back(mk(1, 0, 0, 2, 1, 12'hFFD, 1, 3'd0, 1, 32'd6,        0, 32'd0));
        vecs.push_back(mk(1, 1, 2, 5, 1, 12'd0,   0, 3'd1, 1, 32'hFFFFFFFD, 0, 32'd0));
        vecs.push_back(mk(1, 1, 2, 5, 1, 12'd0,   0, 3'd2, 1, 32'd9,        0, 32'd0));
        vecs.push_back(mk(1, 1, 2, 5, 1, 12'd0,   0, 3'd3, 1, 32'd4,        0, 32'd0));
        vecs.push_back(mk(1, 1, 2, 5, 1, 12'd0,   0, 3'd4, 1, 32'hFFFFFFFF, 0, 32'd0));
        vecs.push_back(mk(1, 2, 1, 5, 1, 12'd0,   0, 3'd5, 1, 32'hFFFFFFFB, 0, 32'd0));
        vecs.push_back(mk(1, 1, 0, 5, 1, 12'd4,   1, 3'd6, 1, 32'd1,        0, 32'd0));
        vecs.push_back(mk(1, 2, 0, 5, 1, 12'd28,  1, 3'd7, 1, 32'd96,       0, 32'd0));
        vecs.push_back(mk(1, 0, 0, 2, 1, 12'd6,   1, 3'd0, 1, 32'hF,        0, 32'd0));
        vecs.push_back(mk(1, 1, 2, 6, 1, 12'd0,   0, 3'd1, 1, 32'd6,        0, 32'd0));
        vecs.push_back(mk(1, 0, 0, 2, 1, 12'd5,   1, 3'd0, 1, 32'd0,        1, 32'd0));
        vecs.push_back(mk(1, 1, 2, 6, 1, 12'd0,   0, 3'd1, 1, 32'd5,        0, 32'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, 3'd0, 1, 32'd1,        0, 32'd0));
        vecs.push_back(mk(1, 0, 0, 10, 1, 12'd42, 1, 3'd0, 0, 32'd1,        0, 32'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, 3'd0, 1, 32'd42,       0, 32'd42));
        vecs.push_back(mk(1, 0, 0, 7, 1, 12'd3,   1, 3'd0, 0, 32'd42,       0, 32'd42));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, 3'd0, 1, 32'd3,        0, 32'd42));
        vecs.push_back(mk(0, 0, 0, 0, 0, 12'd0,   0, 3'd0, 0, 32'd3,        0, 32'd42));

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].v, vecs[k].rs1, vecs[k].rs2, vecs[k].rd, vecs[k].we,
                  vecs[k].imm, vecs[k].src, vecs[k].ctrl);
            step();
            check($sformatf("row%0d out_valid", k), {31'd0, bus.out_valid}, {31'd0, vecs[k].ev});
            check($sformatf("row%0d ALUout", k), bus.ALUout, vecs[k].eout);
            check($sformatf("row%0d EQ", k), {31'd0, bus.EQ}, {31'd0, vecs[k].eeq});
            check($sformatf("row%0d a0", k), bus.a0, vecs[k].ea0);
        end

        // Mid-pipeline reset: x10=99 is in EX when rst rises and must not retire
        drive(1'b1, 5'd0, 5'd0, 5'd10, 1'b1, 12'd99, 1'b1, 3'd0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 12'd0, 1'b0, 3'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst ALUout", bus.ALUout, 32'd0);
        check("rst EQ", {31'd0, bus.EQ}, 32'd0);
        check("rst a0", bus.a0, 32'd0);

        // Former x1=6, x2=5, x3=14, x5, x6, x10 must all read back as zero
        drive(1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 12'd0, 1'b0, 3'd3);
        step();
        check("rst rd0 out_valid", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b1, 5'd3, 5'd5, 5'd0, 1'b0, 12'd0, 1'b0, 3'd3);
        step();
        check("rst x1|x2", bus.ALUout, 32'd0);
        check("rst rd1 out_valid", {31'd0, bus.out_valid}, 32'd1);
        drive(1'b1, 5'd6, 5'd10, 5'd0, 1'b0, 12'd0, 1'b0, 3'd3);
        step();
        check("rst x3|x5", bus.ALUout, 32'd0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 12'd0, 1'b0, 3'd0);
        step();
        check("rst x6|x10", bus.ALUout, 32'd0);
        check("rst x6|x10 EQ", {31'd0, bus.EQ}, 32'd1);
        check("rst a0 after drain", bus.a0, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
